// File: rtl/ign_dwell_ctrl.sv
// ign_dwell_ctrl: per-cylinder ignition coil driver.
// Charges the coil from a dwell-start angle to a spark angle, with a hard
// maximum dwell time, a minimum coil-off hold-off and a sticky timeout fault.
// Optional feature macro IGN_DWELL_MEAS_EN adds the dwell_meas output, which
// reports the coil-on clock count of the last completed dwell.
module ign_dwell_ctrl #(
   parameter int ANGLE_WIDTH = 24,
   parameter int TIMER_WIDTH = 24
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   hwag_start,
   input  logic [ANGLE_WIDTH-1:0] angle,
   input  logic                   angle_ena,
   input  logic                   ena,
   input  logic [ANGLE_WIDTH-1:0] dwell_angle,
   input  logic [ANGLE_WIDTH-1:0] spark_angle,
   input  logic [TIMER_WIDTH-1:0] max_dwell,
   input  logic [TIMER_WIDTH-1:0] min_off,
   input  logic                   fault_clr,
   output logic                   coil_out,
   output logic                   spark_strobe,
   output logic                   fault
`ifdef IGN_DWELL_MEAS_EN
   ,
   output logic [TIMER_WIDTH-1:0] dwell_meas
`endif
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ARMED   = 2'd1,
      ST_DWELL   = 2'd2,
      ST_HOLDOFF = 2'd3
   } state_t;

   localparam logic [TIMER_WIDTH-1:0] TMR_ZERO = '0;
   localparam logic [TIMER_WIDTH-1:0] TMR_ONE  = {{(TIMER_WIDTH-1){1'b0}}, 1'b1};

   // Saturating increment: timers stick at all-ones instead of wrapping.
   function automatic logic [TIMER_WIDTH-1:0] sat_inc(input logic [TIMER_WIDTH-1:0] v);
      return (&v) ? v : v + TMR_ONE;
   endfunction

   state_t                 state_q, state_nxt;
   logic [ANGLE_WIDTH-1:0] dwell_sh, spark_sh;
   logic [TIMER_WIDTH-1:0] dwell_tmr, off_tmr;
   logic                   sync_ok, dwell_hit, spark_hit, timeout;
   logic                   start_dwell, release_ev, timeout_ev;
   logic                   coil_nxt, strobe_nxt, fault_nxt;

   assign sync_ok   = hwag_start & ena;
   assign dwell_hit = angle_ena && (angle == dwell_sh);
   assign spark_hit = angle_ena && (angle == spark_sh);
   assign timeout   = (max_dwell != TMR_ZERO) && (dwell_tmr == max_dwell);

   // State register and registered outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= ST_IDLE;
         coil_out     <= 1'b0;
         spark_strobe <= 1'b0;
         fault        <= 1'b0;
      end else begin
         state_q      <= state_nxt;
         coil_out     <= coil_nxt;
         spark_strobe <= strobe_nxt;
         fault        <= fault_nxt;
      end
   end

   // Next-state decode; sync loss or disable overrides every other transition.
   always_comb begin
      state_nxt   = state_q;
      start_dwell = 1'b0;
      release_ev  = 1'b0;
      timeout_ev  = 1'b0;
      if (!sync_ok) begin
         state_nxt  = ST_IDLE;
         release_ev = (state_q == ST_DWELL);
      end else begin
         case (state_q)
            ST_IDLE: state_nxt = ST_ARMED;
            ST_ARMED: begin
               // A zero-length dwell (dwell == spark) is skipped entirely.
               if (dwell_hit && (dwell_sh != spark_sh)) begin
                  state_nxt   = ST_DWELL;
                  start_dwell = 1'b1;
               end
            end
            ST_DWELL: begin
               // Spark match has priority so a coincident timeout is not a fault.
               if (spark_hit) begin
                  state_nxt  = ST_HOLDOFF;
                  release_ev = 1'b1;
               end else if (timeout) begin
                  state_nxt  = ST_HOLDOFF;
                  release_ev = 1'b1;
                  timeout_ev = 1'b1;
               end
            end
            ST_HOLDOFF: begin
               if (off_tmr == min_off) state_nxt = ST_ARMED;
            end
            default: state_nxt = ST_IDLE;
         endcase
      end
   end

   // Output decode; a new timeout beats a simultaneous fault_clr.
   always_comb begin
      coil_nxt   = coil_out;
      strobe_nxt = 1'b0;
      fault_nxt  = fault;
      if (start_dwell) coil_nxt = 1'b1;
      if (release_ev) begin
         coil_nxt   = 1'b0;
         strobe_nxt = 1'b1;
      end
      if (timeout_ev)     fault_nxt = 1'b1;
      else if (fault_clr) fault_nxt = 1'b0;
   end

   // Angle shadows (frozen during dwell) and the dwell / hold-off timers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         dwell_sh  <= '0;
         spark_sh  <= '0;
         dwell_tmr <= '0;
         off_tmr   <= '0;
      end else begin
         if (state_q != ST_DWELL) begin
            dwell_sh <= dwell_angle;
            spark_sh <= spark_angle;
         end
         if (start_dwell)                dwell_tmr <= TMR_ZERO;
         else if (state_q == ST_DWELL)   dwell_tmr <= sat_inc(dwell_tmr);
         if ((state_nxt == ST_HOLDOFF) && (state_q != ST_HOLDOFF))
            off_tmr <= TMR_ZERO;
         else if (state_q == ST_HOLDOFF)
            off_tmr <= sat_inc(off_tmr);
      end
   end

`ifdef IGN_DWELL_MEAS_EN
   // Capture coil-on clocks on every release; the timer lags the coil by one clk.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) dwell_meas <= '0;
      else if (release_ev) dwell_meas <= sat_inc(dwell_tmr);
   end
`endif

endmodule

// File: tb/tb_ign_dwell_ctrl.sv
// Scoreboard bench for ign_dwell_ctrl: the driver pushes expected coil
// events and state checks; a single negedge monitor pops and compares them.
module tb_ign_dwell_ctrl;
   localparam int AW = 24;
   localparam int TW = 24;
   localparam int EV_RISE = 0;
   localparam int EV_REL  = 1;
   localparam int CYC_LIMIT = 200000;

   logic          clk = 1'b0;
   logic          rst_n, hwag_start, angle_ena, ena, fault_clr;
   logic [AW-1:0] angle, dwell_angle, spark_angle;
   logic [TW-1:0] max_dwell, min_off;
   logic          coil_out, spark_strobe, fault;
`ifdef IGN_DWELL_MEAS_EN
   logic [TW-1:0] dwell_meas;
`endif

   typedef struct {int kind; int cyc; bit flt;} ev_t;
   typedef struct {int cyc; int sel; int expv; string name;} chk_t;

   ev_t   ev_q[$];
   chk_t  chk_q[$];
   int    cyc = 0;
   int    n_checks = 0;
   int    n_fail = 0;
   bit    done = 1'b0;
   bit    exp_fault = 1'b0;
   logic  coil_q = 1'b0;
   chk_t  cur_chk;
   int    act;

   ign_dwell_ctrl #(.ANGLE_WIDTH(AW), .TIMER_WIDTH(TW)) dut (
      .clk(clk), .rst(rst_n), .hwag_start(hwag_start), .angle(angle),
      .angle_ena(angle_ena), .ena(ena), .dwell_angle(dwell_angle),
      .spark_angle(spark_angle), .max_dwell(max_dwell), .min_off(min_off),
      .fault_clr(fault_clr), .coil_out(coil_out), .spark_strobe(spark_strobe),
      .fault(fault)
`ifdef IGN_DWELL_MEAS_EN
      , .dwell_meas(dwell_meas)
`endif
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic int sample(input int sel);
      case (sel)
         0: return int'(coil_out);
         1: return int'(spark_strobe);
         2: return int'(fault);
`ifdef IGN_DWELL_MEAS_EN
         3: return int'(dwell_meas);
`endif
         default: return -1;
      endcase
   endfunction

   task automatic check_ev(input int kind);
      ev_t e;
      n_checks++;
      if (ev_q.size() == 0) begin
         n_fail++;
         $display("FAIL unexpected_event kind=%0d at cycle %0d: got an event, required none", kind, cyc);
      end else begin
         e = ev_q.pop_front();
         if (e.kind != kind || e.cyc != cyc ||
             (kind == EV_REL && (fault != e.flt || coil_out != 1'b0))) begin
            n_fail++;
            $display("FAIL coil_event: got kind %0d cycle %0d fault %0b coil %0b, required kind %0d cycle %0d fault %0b coil %0b",
                     kind, cyc, fault, coil_out, e.kind, e.cyc, e.flt, (e.kind == EV_RISE));
         end
      end
   endtask

   // Monitor: the only process that compares and counts.
   always @(negedge clk) begin
      if (cyc > CYC_LIMIT) begin
         n_fail++;
         $display("FAIL cycle_budget: got %0d cycles, required at most %0d", cyc, CYC_LIMIT);
         $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
         $finish;
      end
      while (chk_q.size() != 0 && chk_q[0].cyc <= cyc) begin
         cur_chk = chk_q.pop_front();
         act = sample(cur_chk.sel);
         n_checks++;
         if (act != cur_chk.expv) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", cur_chk.name, act, cur_chk.expv, cyc);
         end
      end
      if (rst_n) begin
         if (coil_out && !coil_q) check_ev(EV_RISE);
         if (spark_strobe)        check_ev(EV_REL);
      end
      coil_q <= coil_out;
      if (done) begin
         n_checks++;
         if (ev_q.size() != 0) begin
            n_fail++;
            $display("FAIL pending_events: got %0d still outstanding, required 0", ev_q.size());
         end
         $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
         $finish;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_ev(input int kind, input int at, input bit flt);
      ev_t e;
      e.kind = kind; e.cyc = at; e.flt = flt;
      ev_q.push_back(e);
   endtask

   task automatic push_chk(input int sel, input int expv, input string name);
      chk_t c;
      c.cyc = cyc; c.sel = sel; c.expv = expv; c.name = name;
      chk_q.push_back(c);
   endtask

   // Sweep angles a..b, one angle_ena strobe every 4 clks. rise_at/fall_at
   // mark the angles expected to start/end a dwell; to_len > 0 means the
   // dwell is expected to be cut by timeout to_len clks after it rose.
   task automatic sweep(input int a, input int b, input int rise_at, input int fall_at, input int to_len);
      for (int x = a; x <= b; x++) begin
         angle     = AW'(x);
         angle_ena = 1'b1;
         if (x == rise_at) begin
            push_ev(EV_RISE, cyc + 1, exp_fault);
            if (to_len > 0) begin
               exp_fault = 1'b1;
               push_ev(EV_REL, cyc + 1 + to_len, 1'b1);
            end
         end
         if (x == fall_at) push_ev(EV_REL, cyc + 1, exp_fault);
         tick();
         angle_ena = 1'b0;
         tick(); tick(); tick();
      end
   endtask

   initial begin
      rst_n = 1'b0; hwag_start = 1'b1; ena = 1'b1; angle_ena = 1'b0; angle = '0;
      fault_clr = 1'b0; dwell_angle = 24'd100; spark_angle = 24'd200;
      max_dwell = '0; min_off = '0;
      tick(); tick(); tick();
      push_chk(0, 0, "reset_coil");
      push_chk(1, 0, "reset_strobe");
      push_chk(2, 0, "reset_fault");
      rst_n = 1'b1;
      tick(); tick(); tick();

      // Basic dwell over a full revolution.
      sweep(0, 3839, 100, 200, 0);
      push_chk(2, 0, "s1_fault");
`ifdef IGN_DWELL_MEAS_EN
      push_chk(3, 400, "s1_dwell_meas");
`endif

      // Dwell spanning the angle wrap.
      dwell_angle = 24'd3800; spark_angle = 24'd40;
      tick(); tick();
      sweep(3700, 3839, 3800, -1, 0);
      sweep(0, 100, -1, 40, 0);

      // Max-dwell timeout, sticky fault, then clear.
      dwell_angle = 24'd100; spark_angle = 24'd200; max_dwell = 24'd50;
      tick(); tick();
      sweep(0, 300, 100, -1, 51);
      tick(); tick();
      push_chk(2, 1, "s3_fault_sticky");
      fault_clr = 1'b1;
      tick();
      fault_clr = 1'b0;
      exp_fault = 1'b0;
      push_chk(2, 0, "s3_fault_cleared");

      // Spark match and timeout on the same clk: spark wins, no fault.
      dwell_angle = 24'd100; spark_angle = 24'd150; max_dwell = 24'd199;
      tick(); tick();
      sweep(0, 200, 100, 150, 0);
      max_dwell = '0;

      // Hold-off masks a dwell match; mid-dwell dwell_angle change is deferred.
      dwell_angle = 24'd150; spark_angle = 24'd200; min_off = 24'd1000;
      tick(); tick();
      sweep(0, 180, 150, -1, 0);
      dwell_angle = 24'd210;
      sweep(181, 400, -1, 200, 0);
      sweep(401, 3839, -1, -1, 0);
      sweep(0, 220, 210, -1, 0);

      // Sync loss mid-dwell: forced release, no fault, channel goes idle.
      hwag_start = 1'b0;
      push_ev(EV_REL, cyc + 1, 1'b0);
      tick(); tick();
      push_chk(0, 0, "s5_coil_low");
      push_chk(2, 0, "s5_fault");
      sweep(205, 215, -1, -1, 0);
      hwag_start = 1'b1; min_off = '0;
      tick(); tick();

      // dwell == spark: no events over a full revolution.
      dwell_angle = 24'd500; spark_angle = 24'd500;
      tick(); tick();
      sweep(0, 3839, -1, -1, 0);
      tick(); tick();
      done = 1'b1;
   end
endmodule
